pc_unit: RTL
============

# pc_unit

Parametrised program-counter unit for the core's fetch stage, the next generation of the plain `pc` register. It holds the fetch address and selects the next one each cycle from trap, redirect, return-prediction, stall or sequential increment. It carries an internal return-address stack (RAS) so `ret` instructions resolve without waiting for the execute stage. Outputs feed instruction-memory addressing and the branch/return bookkeeping in decode.

## Interface
- `XLEN`, 32, address width in bits.
- `RESET_VEC`, 32'h0100_0000, PC value on reset.
- `TRAP_VEC`, 32'h0000_0100, PC value on trap.
- `INC`, 4, sequential increment in bytes.
- `RAS_DEPTH`, 4, return-address stack entries (≥2, power of two).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `stall`  in  1  hold PC; blocks sequential, call and ret updates.
- `trap`  in  1  force PC to `TRAP_VEC`, clear RAS.
- `redirect_valid`  in  1  branch/jump taken; load `redirect_addr`.
- `redirect_addr`  in  XLEN  redirect target.
- `call`  in  1  qualifies a redirect as a call: push `pc+INC`.
- `ret`  in  1  return: pop RAS top into PC.
- `pc`  out  XLEN  current fetch address (registered).
- `ras_top`  out  XLEN  current RAS top (0 when empty).
- `ras_empty`  out  1  RAS holds no entries.
- `ras_full`  out  1  RAS holds `RAS_DEPTH` entries.
- `ras_underflow`  out  1  sticky: `ret` seen with empty RAS.

## Operation
- Next-PC priority, highest first:
  1. `trap`
  2. `redirect_valid`
  3. `stall`
  4. `ret` with RAS non-empty
  5. sequential
- Trap: `pc <= TRAP_VEC`. RAS count goes to 0. `ras_underflow` is not cleared.
- Redirect: `pc <= redirect_addr`, regardless of `stall`.
  - If `call` is also high, push `pc+INC` (the old pc).
  - `ret` is ignored.
- Stall (no trap or redirect): PC and RAS hold. `call` and `ret` are ignored.
- Ret with RAS non-empty: `pc <= ras_top`, pop.
- Ret with RAS empty: `pc <= pc+INC`, set `ras_underflow`.
- Sequential: `pc <= pc+INC`.
- `call` without `redirect_valid` is ignored.
- Push when full: circular overwrite of the oldest entry. Count saturates at `RAS_DEPTH`, so `ras_full` stays 1.
- Arithmetic: `pc+INC` is modulo 2^XLEN. `32'hFFFF_FFFC+4` wraps to 0.
- `ras_top`, `ras_empty` and `ras_full` are derived combinationally from RAS registers. They reflect state after the last edge.

## Timing
- All state updates occur on the rising `clk` edge. Decision-to-`pc` latency is one cycle.
- Reset, applied asynchronously while `rst`=0:
  - `pc=RESET_VEC`
  - RAS count 0
  - `ras_empty=1`, `ras_full=0`, `ras_top=0`, `ras_underflow=0`
- First sequential advance is on the first rising edge after `rst` deasserts with `stall`=0.
- Reset mid-operation (any cycle, including mid-stall or mid-push) takes effect immediately, without waiting for a clock edge. The in-flight update is discarded.
- Trap plus redirect in the same cycle: trap wins, no push.
- Redirect plus stall: redirect wins.
- Push and pop never occur in the same cycle, because the priority order excludes it.

## Structure
- Shared package `pc_pkg`:
  - default `XLEN`, `RESET_VEC`, `TRAP_VEC`, `INC`
  - a `next_sel_t` enum `{SEL_TRAP, SEL_REDIR, SEL_HOLD, SEL_RET, SEL_SEQ}`, used by the selector and by the bench's scoreboard
- Sub-module `pc_ras`:
  - parametrised LIFO (`XLEN`, `RAS_DEPTH`) with push, pop, clear, top, empty, full
  - circular pointer plus saturating count
  - same `clk`/`rst` as the parent
- The top level holds the PC register and the priority selector only.

## Test plan
- Reset: hold `rst`=0 for 2 cycles, then release -> `pc`=32'h0100_0000 during reset. After 3 free cycles `pc`=32'h0100_000C. `ras_empty`=1.
- Call/return: at pc=32'h0100_0004 assert `redirect_valid`+`call`, `redirect_addr`=32'h200 -> next `pc`=32'h200, `ras_top`=32'h0100_0008. Then `ret` -> `pc`=32'h0100_0008, `ras_empty`=1.
- Overflow/underflow, 5 calls with `RAS_DEPTH`=4:
  - `ras_full`=1 after the 4th call.
  - 4 rets return the last 4 pushed addresses in LIFO order.
  - A 5th ret gives `pc`=previous+4 and `ras_underflow`=1.
- Priority: the same cycle with `trap`, `redirect_valid`, `stall` and `ret` all high -> `pc`=32'h100, RAS cleared. Redirect+stall -> `pc`=`redirect_addr`.
- Stall: `stall`=1 for 3 cycles with `ret` high and RAS non-empty -> `pc` and `ras_top` unchanged throughout.
- Wrap and async reset:
  - `redirect_addr`=32'hFFFF_FFFC, then one free cycle -> `pc`=0.
  - Drop `rst` between edges -> `pc`=32'h0100_0000 before the next edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared defaults and next-PC selector encoding for the fetch-stage PC unit.
`timescale 1ns/1ps
package pc_pkg;

    localparam int unsigned DEF_XLEN      = 32;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0100_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;
    localparam int unsigned DEF_INC       = 4;
    localparam int unsigned DEF_RAS_DEPTH = 4;

    typedef enum logic [2:0] {
        SEL_TRAP,
        SEL_REDIR,
        SEL_HOLD,
        SEL_RET,
        SEL_SEQ
    } next_sel_t;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular LIFO whose pushes overwrite the oldest entry when full.
`timescale 1ns/1ps
module pc_ras #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    // Write pointer addresses the next free slot; the top lives one below it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (count != CW'(RAS_DEPTH)) begin
                count <= count + CW'(1);
            end
        end else if (pop && (count != '0)) begin
            wr_ptr <= wr_ptr - PW'(1);
            count  <= count - CW'(1);
        end
    end

    // Entry storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign empty = (count == '0);
    assign full  = (count == CW'(RAS_DEPTH));
    assign top   = empty ? '0 : mem[wr_ptr - PW'(1)];

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with trap/redirect/ret/stall priority selection and a return-address stack.
`timescale 1ns/1ps
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN      = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
    parameter int unsigned     INC       = DEF_INC,
    parameter int unsigned     RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            trap,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    input  logic            call,
    input  logic            ret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_underflow
);

    next_sel_t       sel;
    logic            push;
    logic            pop;
    logic            clear;
    logic            uf_set;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] pc_next;

    assign pc_inc = pc + XLEN'(INC);

    // Priority selector; a ret against an empty stack falls through to sequential.
    always_comb begin
        sel     = SEL_SEQ;
        push    = 1'b0;
        pop     = 1'b0;
        clear   = 1'b0;
        uf_set  = 1'b0;
        pc_next = pc_inc;
        if (trap) begin
            sel = SEL_TRAP;
        end else if (redirect_valid) begin
            sel = SEL_REDIR;
        end else if (stall) begin
            sel = SEL_HOLD;
        end else if (ret && !ras_empty) begin
            sel = SEL_RET;
        end else if (ret) begin
            uf_set = 1'b1;
        end
        case (sel)
            SEL_TRAP: begin
                pc_next = TRAP_VEC;
                clear   = 1'b1;
            end
            SEL_REDIR: begin
                pc_next = redirect_addr;
                push    = call;
            end
            SEL_HOLD: pc_next = pc;
            SEL_RET: begin
                pc_next = ras_top;
                pop     = 1'b1;
            end
            default: pc_next = pc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc            <= RESET_VEC;
            ras_underflow <= 1'b0;
        end else begin
            pc <= pc_next;
            if (uf_set) begin
                ras_underflow <= 1'b1;
            end
        end
    end

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .push_data (pc_inc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

endmodule
